// File: rtl/pe_feeder_pkg.sv
// rtl/pe_feeder_pkg.sv - shared widths, PE latency and FSM state encoding for the PE feeder
package pe_feeder_pkg;
  localparam int ELE_BITS  = 8;
  localparam int LANES     = 8;
  localparam int BIAS_BITS = 32;
  localparam int PE_LAT    = 8;
  localparam int DATA_W    = ELE_BITS * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/pe_feeder_dly.sv
// rtl/pe_feeder_dly.sv - 1-bit shift register; q_o follows d_i after DEPTH clocks
module pe_feeder_dly #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;

  // Shift-and-or form keeps DEPTH = 1 legal.
  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= (sr_q << 1) | DEPTH'(d_i);
  end

  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - sequences activation/kernel/bias beats into a PE with bias skew and flush
module pe_feeder
  import pe_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8:0]           cfg_rounds,
  input  logic [15:0]          cfg_groups,
  input  logic [DATA_W-1:0]    act_data,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [DATA_W-1:0]    ker_data,
  input  logic                 ker_valid,
  output logic                 ker_ready,
  input  logic [BIAS_BITS-1:0] bias_data,
  input  logic [3:0]           bias_off,
  input  logic                 bias_valid,
  output logic                 bias_ready,
  output logic                 pe_valid_in,
  output logic                 pe_final_in,
  output logic [DATA_W-1:0]    pe_act,
  output logic [DATA_W-1:0]    pe_ker,
  output logic [BIAS_BITS-1:0] pe_bias,
  output logic [3:0]           pe_bias_offset,
  output logic                 busy,
  output logic                 done,
  output logic                 out_discard
);
  state_t                 state_q;
  logic [8:0]             rounds_q, beat_q;
  logic [15:0]            groups_q, group_q;
  logic                   busy_q, done_q;
  logic [BIAS_BITS-1:0]   hold_bias_q;
  logic [3:0]             hold_off_q;

  logic                   valid_q, final_q, disc_in_q;
  logic [DATA_W-1:0]      s1_act_q, s1_ker_q, act_q, ker_q;
  logic [BIAS_BITS-1:0]   s1_bias_q, bias_q;
  logic [3:0]             s1_off_q, off_q;

  logic beat0, fire, flush, last_beat, last_group, done_tick, present_bias;

  assign beat0      = (beat_q == 9'd0);
  assign fire       = (state_q == RUN) && act_valid && ker_valid && (!beat0 || bias_valid);
  assign flush      = (state_q == FLUSH);
  assign last_beat  = (beat_q == rounds_q - 9'd1);
  assign last_group = (group_q == groups_q - 16'd1);
  // Beat 0 and the flush beat carry the bias of the group that just finished.
  assign present_bias = (fire && beat0) || flush;

  assign act_ready  = fire;
  assign ker_ready  = fire;
  assign bias_ready = fire && beat0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rounds_q    <= 9'd0;
      groups_q    <= 16'd0;
      beat_q      <= 9'd0;
      group_q     <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hold_bias_q <= '0;
      hold_off_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (cfg_groups == 16'd0) begin
            done_q <= 1'b1;
          end else begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            rounds_q    <= (cfg_rounds == 9'd0) ? 9'd1 : cfg_rounds;
            groups_q    <= cfg_groups;
            beat_q      <= 9'd0;
            group_q     <= 16'd0;
            hold_bias_q <= '0;
            hold_off_q  <= 4'd0;
          end
        end
        RUN: if (fire) begin
          if (beat0) begin
            hold_bias_q <= bias_data;
            hold_off_q  <= bias_off;
          end
          if (last_beat) begin
            beat_q <= 9'd0;
            if (last_group) state_q <= FLUSH;
            else            group_q <= group_q + 16'd1;
          end else begin
            beat_q <= beat_q + 9'd1;
          end
        end
        FLUSH: state_q <= DRAIN;
        DRAIN: if (done_tick) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes lead by one stage; operands go through two so data trails valid by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      final_q   <= 1'b0;
      disc_in_q <= 1'b0;
      s1_act_q  <= '0;
      s1_ker_q  <= '0;
      s1_bias_q <= '0;
      s1_off_q  <= 4'd0;
      act_q     <= '0;
      ker_q     <= '0;
      bias_q    <= '0;
      off_q     <= 4'd0;
    end else begin
      valid_q   <= fire || flush;
      final_q   <= (fire && beat0) || flush;
      disc_in_q <= fire && beat0 && (group_q == 16'd0);
      s1_act_q  <= fire ? act_data : '0;
      s1_ker_q  <= fire ? ker_data : '0;
      s1_bias_q <= present_bias ? hold_bias_q : '0;
      s1_off_q  <= present_bias ? hold_off_q : 4'd0;
      act_q     <= s1_act_q;
      ker_q     <= s1_ker_q;
      bias_q    <= s1_bias_q;
      off_q     <= s1_off_q;
    end
  end

  pe_feeder_dly #(.DEPTH(PE_LAT)) u_discard_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (disc_in_q),
    .q_o   (out_discard)
  );

  pe_feeder_dly #(.DEPTH(PE_LAT)) u_done_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (flush),
    .q_o   (done_tick)
  );

  assign pe_valid_in    = valid_q;
  assign pe_final_in    = final_q;
  assign pe_act         = act_q;
  assign pe_ker         = ker_q;
  assign pe_bias        = bias_q;
  assign pe_bias_offset = off_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule
